// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: shares one combinational sigmoid LUT among N_REQ requesters.
// Round-robin grant by default; define SIGMOID_ARB_FIXED_PRI_EN for fixed
// priority (lowest index wins, no rotating pointer).
// Pipeline: grant/handshake -> lut_z register -> rsp_h register (2-cycle latency).
module sigmoid_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_z,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         lut_z,
  input  logic [7:0]         lut_h,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_h,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);

  localparam int unsigned Z_W = 8;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gidx;
  logic             hs;
  logic [Z_W-1:0]   sel_z;
  logic             v1;
  logic [ID_W-1:0]  id1;
  logic [N_REQ-1:0] rsp_valid_d;

`ifdef SIGMOID_ARB_FIXED_PRI_EN
  // Fixed priority: lowest-indexed valid requester wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    hs    = 1'b0;
    if (rst_n && en) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!hs && req_valid[k]) begin
          hs       = 1'b1;
          grant[k] = 1'b1;
          gidx     = ID_W'(k);
        end
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;
  int unsigned     idx;

  // Round-robin: first valid requester at or above ptr, wrapping to 0
  always_comb begin
    grant = '0;
    gidx  = '0;
    hs    = 1'b0;
    idx   = 0;
    if (rst_n && en) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!hs && req_valid[ID_W'(idx)]) begin
          hs                   = 1'b1;
          grant[ID_W'(idx)]    = 1'b1;
          gidx                 = ID_W'(idx);
        end
      end
    end
  end

  // Pointer advances past the granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
    end
  end
`endif

  // Select the granted requester's z
  always_comb begin
    sel_z = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_z = req_z[Z_W*i +: Z_W];
    end
  end

  // One-hot response strobe for the stage-1 owner
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = v1 && (id1 == ID_W'(i));
    end
  end

  // Stage 1 (LUT input) and stage 2 (response) registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      id1       <= '0;
      lut_z     <= '0;
      rsp_valid <= '0;
      rsp_h     <= '0;
      rsp_id    <= '0;
    end else begin
      v1        <= hs;
      rsp_valid <= rsp_valid_d;
      if (hs) begin
        lut_z <= sel_z;
        id1   <= gidx;
      end
      if (v1) begin
        rsp_h  <= lut_h;
        rsp_id <= id1;
      end
    end
  end

  assign req_ready = grant;
  assign busy      = v1 | (|rsp_valid);

endmodule
